// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

  // Default geometry of the program/data RAM
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 12;

  // Port indices: CPU core and secondary master (frame fetcher / loader)
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Arbiter sequencing: sample, RAM command cycle, RAM output valid
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RD   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between the two RAM requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only uses the result while idle.
// RAM_ARB_RR_EN selects round-robin on the pointer, otherwise port 0 wins ties.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef RAM_ARB_RR_EN
  input  logic i_ptr,
`endif
  output logic o_vld,
  output logic o_idx
);

  // Any request is a valid pick; the tie-break is the only mode-dependent part
  always_comb begin
    o_vld = i_req0 | i_req1;
    o_idx = PORT_CPU;
`ifdef RAM_ARB_RR_EN
    if (i_req0 && i_req1) begin
      o_idx = i_ptr;
    end else if (i_req1) begin
      o_idx = PORT_AUX;
    end
`else
    if (!i_req0 && i_req1) begin
      o_idx = PORT_AUX;
    end
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port registered-output RAM between the CPU (port 0) and an aux master (port 1).
// Latency: gnt 1 cycle after sampling; write occupies 2 cycles, read delivers rvalid 3 cycles after sampling.
// Backpressure: one command at a time; requests are only sampled in IDLE and must be held until gnt.
// Optional feature macro: RAM_ARB_RR_EN (round-robin tie-break; fixed port-0 priority when undefined).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_pll,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_q
);

  state_t              r_state;
  logic                r_win;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ram_we;
  logic                w_vld;
  logic                w_idx;

`ifdef RAM_ARB_RR_EN
  logic                r_ptr;

  // Tie-break pointer moves to the other port after every grant
  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      r_ptr <= PORT_CPU;
    end else if (r_state == ST_IDLE && w_vld) begin
      r_ptr <= ~w_idx;
    end
  end
`endif

  ram_arb_pick u_pick (
    .i_req0 (i_req0),
    .i_req1 (i_req1),
`ifdef RAM_ARB_RR_EN
    .i_ptr  (r_ptr),
`endif
    .o_vld  (w_vld),
    .o_idx  (w_idx)
  );

  // Sequencer: latch the winner's command, run the RAM cycle, return read data
  always_ff @(posedge clk_pll or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_win      <= PORT_CPU;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ram_we <= 1'b0;
          if (w_vld) begin
            r_win   <= w_idx;
            r_state <= ST_ACC;
            if (w_idx == PORT_AUX) begin
              r_ram_addr <= i_addr1;
              r_ram_din  <= i_wdata1;
              r_ram_we   <= i_we1;
              r_gnt1     <= 1'b1;
            end else begin
              r_ram_addr <= i_addr0;
              r_ram_din  <= i_wdata0;
              r_ram_we   <= i_we0;
              r_gnt0     <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          // ram_we is still high here exactly when the command is a write
          r_ram_we <= 1'b0;
          r_state  <= r_ram_we ? ST_IDLE : ST_RD;
        end
        ST_RD: begin
          if (r_win == PORT_AUX) begin
            r_rdata1  <= i_ram_q;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= i_ram_q;
            r_rvalid0 <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0     = r_gnt0;
  assign o_gnt1     = r_gnt1;
  assign o_rvalid0  = r_rvalid0;
  assign o_rvalid1  = r_rvalid1;
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_ram_we   = r_ram_we;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, golden memory image and randomized traffic.
// Latency: n/a.
// Backpressure: requesters hold their command until gnt, then drop it.
module tb_ram_arbiter;

  logic        clk_pll = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [11:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [11:0] rdata0, rdata1;
  logic [9:0]  ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_q;

  logic [11:0] mem  [0:1023] = '{default: '0};
  logic [11:0] gold [0:1023] = '{default: '0};

  int n_tests  = 0;
  int n_fail   = 0;
  int tie_pref = 0;

  always #5 clk_pll = ~clk_pll;

  ram_arbiter dut (
    .clk_pll    (clk_pll),
    .rst        (rst),
    .i_req0     (req0),
    .i_we0      (we0),
    .i_addr0    (addr0),
    .i_wdata0   (wdata0),
    .i_req1     (req1),
    .i_we1      (we1),
    .i_addr1    (addr1),
    .i_wdata1   (wdata1),
    .o_gnt0     (gnt0),
    .o_gnt1     (gnt1),
    .o_rvalid0  (rvalid0),
    .o_rvalid1  (rvalid1),
    .o_rdata0   (rdata0),
    .o_rdata1   (rdata1),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .o_ram_we   (ram_we),
    .i_ram_q    (ram_q)
  );

  // Single-port RAM with registered output, old data on read-during-write
  always @(posedge clk_pll) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [9:0] a, input logic [11:0] d);
    if (port == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // One isolated access; reports observed latencies, called at a negedge with the DUT idle
  task automatic access(input int port, input logic we, input logic [9:0] addr,
                        input logic [11:0] wd, output int gnt_lat, output int we_cyc,
                        output int rv_lat, output logic [11:0] rd);
    gnt_lat = -1; we_cyc = 0; rv_lat = -1; rd = '0;
    drive(port, 1'b1, we, addr, wd);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_pll);
      if ((port == 0) ? gnt0 : gnt1) begin
        gnt_lat = c;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, 10'h000, 12'h000);
    if (gnt_lat < 0) return;
    if (ram_we) we_cyc++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_pll);
      if (ram_we) we_cyc++;
      if (rv_lat < 0 && ((port == 0) ? rvalid0 : rvalid1)) begin
        rv_lat = c;
        rd = (port == 0) ? rdata0 : rdata1;
      end
    end
    tie_pref = 1 - port;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h2AA, 12'hFFF);
    drive(1, 1'b0, 1'b0, 10'h000, 12'h000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_pll);
      n_tests++;
      if ({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_we} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b rd0=%h rd1=%h addr=%h din=%h we=%b, want all 0",
                 gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_we);
      end
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (gnt0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_nognt: gnt0=%b want 0", gnt0);
    end
    @(negedge clk_pll);
    n_tests++;
    if ({gnt0, ram_we, ram_addr} !== {1'b1, 1'b1, 10'h2AA}) begin
      n_fail++;
      $display("FAIL reset_first_gnt: gnt0=%b we=%b addr=%h want 1 1 2aa", gnt0, ram_we, ram_addr);
    end
    drive(0, 1'b0, 1'b0, 10'h000, 12'h000);
    gold[10'h2AA] = 12'hFFF;
    tie_pref = 1;
    @(negedge clk_pll);
    n_tests++;
    if ({gnt0, ram_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt_pulse: gnt0=%b we=%b want 0 0", gnt0, ram_we);
    end
    @(negedge clk_pll);
  endtask

  task automatic test_write_read();
    int gl, wc, rl;
    logic [11:0] rd;
    access(0, 1'b1, 10'h012, 12'hA5C, gl, wc, rl, rd);
    gold[10'h012] = 12'hA5C;
    n_tests++;
    if (gl !== 1 || wc !== 1) begin
      n_fail++;
      $display("FAIL wr_timing: gnt_lat=%0d we_cycles=%0d want 1 1", gl, wc);
    end
    access(0, 1'b0, 10'h012, 12'h000, gl, wc, rl, rd);
    n_tests++;
    if (gl !== 1 || wc !== 0 || rl !== 2) begin
      n_fail++;
      $display("FAIL rd_timing: gnt_lat=%0d we_cycles=%0d rv_lat=%0d want 1 0 2", gl, wc, rl);
    end
    n_tests++;
    if (rd !== 12'hA5C) begin
      n_fail++;
      $display("FAIL rd_data: rdata0=%h want a5c", rd);
    end
    @(negedge clk_pll);
    n_tests++;
    if (rdata0 !== 12'hA5C) begin
      n_fail++;
      $display("FAIL rd_hold: rdata0=%h want a5c", rdata0);
    end
  endtask

  task automatic test_random();
    int gl, wc, rl, port;
    logic we;
    logic [9:0] a;
    logic [11:0] wd, rd;
    for (int i = 0; i < 12; i++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a    = 10'(32'h40 + $urandom_range(0, 7));
      wd   = 12'($urandom);
      access(port, we, a, wd, gl, wc, rl, rd);
      n_tests++;
      if (gl !== 1 || wc !== (we ? 1 : 0) || rl !== (we ? -1 : 2)) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: port=%0d we=%b gnt_lat=%0d we_cycles=%0d rv_lat=%0d",
                 i, port, we, gl, wc, rl);
      end
      if (we) begin
        gold[a] = wd;
      end else begin
        n_tests++;
        if (rd !== gold[a]) begin
          n_fail++;
          $display("FAIL rand_rdata[%0d]: port=%0d addr=%h got %h want %h", i, port, a, rd, gold[a]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int gl, wc, rl, n, bad, pref, expv;
    int order [8];
    logic [11:0] rd;
    access(0, 1'b1, 10'h100, 12'h111, gl, wc, rl, rd);
    gold[10'h100] = 12'h111;
    access(1, 1'b1, 10'h101, 12'h222, gl, wc, rl, rd);
    gold[10'h101] = 12'h222;
    for (int k = 0; k < 8; k++) order[k] = -1;
    n = 0; bad = 0;
    drive(0, 1'b1, 1'b0, 10'h100, 12'h000);
    drive(1, 1'b1, 1'b0, 10'h101, 12'h000);
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk_pll);
      if ((gnt0 && rvalid0) || (gnt1 && rvalid1) || (gnt0 && gnt1)) bad++;
      if (rvalid0 && rdata0 !== gold[10'h100]) bad++;
      if (rvalid1 && rdata1 !== gold[10'h101]) bad++;
      if (gnt0) begin order[n] = 0; n++; end
      if (gnt1 && n < 8) begin order[n] = 1; n++; end
    end
    drive(0, 1'b0, 1'b0, 10'h000, 12'h000);
    drive(1, 1'b0, 1'b0, 10'h000, 12'h000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_pll);
      if ((gnt0 && rvalid0) || (gnt1 && rvalid1) || gnt0 || gnt1) bad++;
      if (rvalid0 && rdata0 !== gold[10'h100]) bad++;
      if (rvalid1 && rdata1 !== gold[10'h101]) bad++;
    end
    n_tests++;
    if (n !== 8 || bad !== 0) begin
      n_fail++;
      $display("FAIL contention_protocol: grants=%0d want 8, violations=%0d want 0", n, bad);
    end
    pref = tie_pref;
    expv = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef RAM_ARB_RR_EN
      expv = pref;
      pref = 1 - pref;
`else
      expv = 0;
`endif
      n_tests++;
      if (order[k] !== expv) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: granted port %0d want %0d", k, order[k], expv);
      end
    end
    tie_pref = 1 - expv;
  endtask

  task automatic test_read_then_write();
    int gl, wc, rl, gap;
    logic [11:0] rd, rd1;
    logic seen_g0;
    access(1, 1'b1, 10'h3FF, 12'h0F0, gl, wc, rl, rd);
    gold[10'h3FF] = 12'h0F0;
    drive(1, 1'b1, 1'b0, 10'h3FF, 12'h000);
    gl = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_pll);
      if (gnt1) begin gl = c; break; end
    end
    drive(1, 1'b0, 1'b0, 10'h000, 12'h000);
    drive(0, 1'b1, 1'b1, 10'h3FF, 12'hE1D);
    seen_g0 = 1'b0; gap = -1; rd1 = 12'h000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_pll);
      if (rvalid1) rd1 = rdata1;
      if (gnt0 && !seen_g0) begin
        seen_g0 = 1'b1;
        gap = c;
        drive(0, 1'b0, 1'b0, 10'h000, 12'h000);
      end
    end
    drive(0, 1'b0, 1'b0, 10'h000, 12'h000);
    n_tests++;
    if (gl !== 1 || rd1 !== 12'h0F0) begin
      n_fail++;
      $display("FAIL rw_old_data: gnt_lat=%0d rdata1=%h want 1 0f0", gl, rd1);
    end
    n_tests++;
    if (gap !== 3) begin
      n_fail++;
      $display("FAIL rw_next_gnt: gnt0 %0d cycles after gnt1, want 3", gap);
    end
    gold[10'h3FF] = 12'hE1D;
    tie_pref = 1;
    access(1, 1'b0, 10'h3FF, 12'h000, gl, wc, rl, rd);
    n_tests++;
    if (rd !== gold[10'h3FF] || rl !== 2) begin
      n_fail++;
      $display("FAIL rw_new_data: rdata1=%h rv_lat=%0d want e1d 2", rd, rl);
    end
  endtask

  task automatic test_reset_mid();
    int gl, wc, rl, bad;
    logic [11:0] rd;
    drive(1, 1'b1, 1'b1, 10'h155, 12'h3C3);
    gl = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_pll);
      if (gnt1) begin gl = c; break; end
    end
    drive(1, 1'b0, 1'b0, 10'h000, 12'h000);
    n_tests++;
    if (gl !== 1 || ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_acc: gnt_lat=%0d ram_we=%b want 1 1", gl, ram_we);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({ram_we, gnt1} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_async: ram_we=%b gnt1=%b want 0 0", ram_we, gnt1);
    end
    @(negedge clk_pll);
    @(negedge clk_pll);
    rst = 1'b1;
    tie_pref = 0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_pll);
      if (gnt1 || rvalid1 || ram_we || gnt0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: %0d cycles with activity after release, want 0", bad);
    end
    access(0, 1'b0, 10'h012, 12'h000, gl, wc, rl, rd);
    n_tests++;
    if (gl !== 1 || rl !== 2 || rd !== gold[10'h012]) begin
      n_fail++;
      $display("FAIL midrst_idle: gnt_lat=%0d rv_lat=%0d rdata0=%h want 1 2 %h",
               gl, rl, rd, gold[10'h012]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 10'h000, 12'h000);
    drive(1, 1'b0, 1'b0, 10'h000, 12'h000);
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_random();
    test_contention();
    test_read_then_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port program/data RAM (registered output, one-cycle read latency) between the CPU core (port 0) and a secondary master such as an OLED frame fetcher or debug loader (port 1). It accepts one request at a time, drives the RAM address, data and write-enable, and returns read data with a valid pulse to the granted port. It sits between the CPU/peripheral masters and the `ram` instance, in the `clk_pll` domain.

## Interface
- `ADDR_W`, 10, RAM address width
- `DATA_W`, 12, RAM data width
- `clk_pll`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  access request from port 0 / port 1
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while the matching `req` is high
- `addr0` / `addr1`  in  ADDR_W  access address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `gnt0` / `gnt1`  out  1  one-cycle pulse: command accepted
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` is valid
- `rdata0` / `rdata1`  out  DATA_W  read data, held until the next read on that port
- `ram_addr`  out  ADDR_W  RAM address
- `ram_din`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_q`  in  DATA_W  RAM registered output

## Operation
- FSM states:
  - IDLE: sample requests.
  - ACC: RAM command cycle.
  - RD: RAM output valid.
- IDLE, no request: stay in IDLE; `ram_we` = 0.
- IDLE, any request: pick a winner.
  - Register `ram_addr`, `ram_din`, `ram_we` from the winner.
  - Set the winner's `gnt`.
  - Go to ACC.
- ACC:
  - Clear `gnt` and `ram_we`.
  - If the command is a write, go to IDLE; otherwise go to RD.
  - `ram_addr` holds its value.
- RD:
  - Capture `ram_q` into the winner's `rdata`.
  - Pulse the winner's `rvalid`.
  - Go to IDLE.
- Requests are ignored outside IDLE.
- Requester rules:
  - A requester holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt`.
  - `req` still high on the edge after `gnt` counts as a new, back-to-back request.
- Simultaneous `req0` and `req1`: the winner follows the priority policy (Configuration). The loser stays pending and is evaluated again in the next IDLE.
- Reset values:
  - all `gnt`, `rvalid` = 0
  - `rdata0`/`rdata1`, `ram_addr`, `ram_din` = 0
  - `ram_we` = 0
  - state = IDLE
  - priority pointer = port 0
- Reset asserted mid-transaction aborts it immediately. `ram_we` drops asynchronously, so a write in ACC may not complete. No `rvalid` is produced.
- A `gnt` and `rvalid` for the same port are never asserted in the same cycle.

## Timing
- Sampling edge E0 (IDLE, req high) to `gnt`: high in the cycle after E0 (ACC).
- RAM samples the command at E1, the end of ACC.
- Write: 2 cycles; a new request can be sampled at E1 + 1 cycle.
- Read:
  - `ram_q` is valid during RD.
  - `rvalid` and `rdata` are visible in the cycle after E2, concurrent with IDLE.
  - Total 3 cycles from the sampling edge to the `rvalid` cycle.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- The arbiter samples the next request in the same cycle that `rvalid` is high.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin.
  - After a grant to port x, the pointer moves to the other port.
  - With both requests continuously high, grants alternate 0,1,0,1.
- `RAM_ARB_RR_EN` undefined: fixed priority.
  - Port 0 (CPU) always wins a tie.
  - The pointer register is not built.
  - Port 1 is served only in an IDLE cycle with `req0` = 0.

## Structure
- Package `ram_arb_pkg`:
  - state enum typedef (IDLE/ACC/RD)
  - port index constants `PORT_CPU` = 0 and `PORT_AUX` = 1
  - default `ADDR_W`/`DATA_W` constants
- Sub-module `ram_arb_pick`: combinational winner selection.
  - Inputs: `req0`, `req1`, pointer.
  - Outputs: valid, winner index.
  - The round-robin/fixed choice is confined to this sub-module.

## Test plan
- Reset: hold `rst` = 0 with `req0` = 1 → all outputs 0; no `gnt` until 1 cycle after release.
- Port 0 write of 12'hA5C to 10'h012, then a port 0 read of 10'h012 → `gnt0` one cycle after each sample; `ram_we` high exactly one cycle; `rvalid0` 2 cycles after the read `gnt0`; `rdata0` = 12'hA5C.
- `req0` and `req1` both reads held high for 8 grants:
  - With `RAM_ARB_RR_EN`: grant order 0,1,0,1,…
  - Without it: port 0 only; `gnt1` never asserted.
- Port 1 read of 10'h3FF while port 0 writes 10'h3FF in the following IDLE → `rdata1` = old value; the later read returns the new value.
- Assert `rst` during ACC of a port 1 write → `ram_we` drops the same cycle; no `gnt1`/`rvalid1` after release; FSM in IDLE.
